// File: rtl/anticipator_update_pkg.sv
// ============================================================================
// Module : anticipator_update_pkg
// Brief  : Shared constants and counter-update helper for the anticipator RAM.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package anticipator_update_pkg;

    localparam int ANT_ADDR_W = 12;
    localparam int ANT_CNT_W  = 2;
    localparam logic [ANT_CNT_W-1:0] ANT_INIT_VAL = 2'b10;

    localparam int c_lanes = 4;

    localparam logic [0:0] c_st_init = 1'b0;
    localparam logic [0:0] c_st_run  = 1'b1;

    // 2-bit saturating counter step, also used by the predictor-side model
    function automatic logic [ANT_CNT_W-1:0] ant_sat_upd(
        input logic [ANT_CNT_W-1:0] cnt,
        input logic                 taken
    );
        if (taken)
            return (cnt == '1) ? cnt : cnt + ANT_CNT_W'(1);
        else
            return (cnt == '0) ? cnt : cnt - ANT_CNT_W'(1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/anticipator_upd_fifo.sv
// ============================================================================
// Module : anticipator_upd_fifo
// Brief  : 4-in / 2-out compacting update FIFO with count, free and two heads.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module anticipator_upd_fifo
    import anticipator_update_pkg::*;
#(
    parameter int ADDR_W = ANT_ADDR_W,
    parameter int DEPTH  = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [c_lanes-1:0]               push_en,
    input  logic [c_lanes-1:0][ADDR_W-1:0]   push_addr,
    input  logic [c_lanes-1:0][1:0]          push_cnt,
    input  logic [c_lanes-1:0]               push_taken,
    input  logic [1:0]                       pop_n,
    output logic [$clog2(DEPTH):0]           count,
    output logic [$clog2(DEPTH):0]           free,
    output logic [2:0]                       push_acc,
    output logic [ADDR_W-1:0]                head0_addr,
    output logic [1:0]                       head0_upd,
    output logic [1:0]                       head0_cnt,
    output logic                             head0_taken,
    output logic [ADDR_W-1:0]                head1_addr,
    output logic [1:0]                       head1_upd,
    output logic                             head1_taken
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [ADDR_W-1:0] r_mem_addr  [DEPTH];
    logic [1:0]        r_mem_upd   [DEPTH];
    logic [1:0]        r_mem_cnt   [DEPTH];
    logic              r_mem_taken [DEPTH];

    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] w_rd_ptr1;
    logic [CW-1:0] r_count;

    logic [c_lanes-1:0]      w_lane_ok;
    logic [c_lanes-1:0][1:0] w_lane_slot;
    logic [2:0]              w_acc;

    assign free  = CW'(DEPTH) - r_count;
    assign count = r_count;

    // Acceptance is a prefix of the enabled lanes, so the slot is the running accept count
    always_comb begin
        w_acc       = '0;
        w_lane_ok   = '0;
        w_lane_slot = '0;
        for (int i = 0; i < c_lanes; i++) begin
            w_lane_slot[i] = w_acc[1:0];
            if (push_en[i] && (CW'(w_acc) < free)) begin
                w_lane_ok[i] = 1'b1;
                w_acc        = w_acc + 3'd1;
            end
        end
    end

    assign push_acc = w_acc;

    always_ff @(posedge clk) begin
        for (int i = 0; i < c_lanes; i++) begin
            if (w_lane_ok[i]) begin
                r_mem_addr [r_wr_ptr + PW'(w_lane_slot[i])] <= push_addr[i];
                r_mem_upd  [r_wr_ptr + PW'(w_lane_slot[i])] <= ant_sat_upd(push_cnt[i], push_taken[i]);
                r_mem_cnt  [r_wr_ptr + PW'(w_lane_slot[i])] <= push_cnt[i];
                r_mem_taken[r_wr_ptr + PW'(w_lane_slot[i])] <= push_taken[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + PW'(w_acc);
            r_rd_ptr <= r_rd_ptr + PW'(pop_n);
            r_count  <= r_count + CW'(w_acc) - CW'(pop_n);
        end
    end

    assign w_rd_ptr1   = r_rd_ptr + PW'(1);
    assign head0_addr  = r_mem_addr [r_rd_ptr];
    assign head0_upd   = r_mem_upd  [r_rd_ptr];
    assign head0_cnt   = r_mem_cnt  [r_rd_ptr];
    assign head0_taken = r_mem_taken[r_rd_ptr];
    assign head1_addr  = r_mem_addr [w_rd_ptr1];
    assign head1_upd   = r_mem_upd  [w_rd_ptr1];
    assign head1_taken = r_mem_taken[w_rd_ptr1];

endmodule

`default_nettype wire

// File: rtl/anticipator_update.sv
// ============================================================================
// Module : anticipator_update
// Brief  : Write-side feeder for the 4096x2b anticipator RAM (init sweep, queue, coalesce).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module anticipator_update
    import anticipator_update_pkg::*;
#(
    parameter int         ADDR_W   = ANT_ADDR_W,
    parameter int         DEPTH    = 16,
    parameter logic [1:0] INIT_VAL = ANT_INIT_VAL,
    parameter int         DROP_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              res0_en,
    input  logic [ADDR_W-1:0] res0_addr,
    input  logic [1:0]        res0_cnt,
    input  logic              res0_taken,
    input  logic              res1_en,
    input  logic [ADDR_W-1:0] res1_addr,
    input  logic [1:0]        res1_cnt,
    input  logic              res1_taken,
    input  logic              res2_en,
    input  logic [ADDR_W-1:0] res2_addr,
    input  logic [1:0]        res2_cnt,
    input  logic              res2_taken,
    input  logic              res3_en,
    input  logic [ADDR_W-1:0] res3_addr,
    input  logic [1:0]        res3_cnt,
    input  logic              res3_taken,
    output logic              res_stall,
    output logic [ADDR_W-1:0] write0_addr,
    output logic [1:0]        write0_data,
    output logic              write0_wen,
    output logic [ADDR_W-1:0] write1_addr,
    output logic [1:0]        write1_data,
    output logic              write1_wen,
    output logic              init_done,
    output logic [DROP_W-1:0] drop_cnt
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [ADDR_W-1:0] c_ptr_last = {{(ADDR_W-1){1'b1}}, 1'b0};

    logic [0:0]        r_state;
    logic [0:0]        w_state_nxt;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W-1:0] w_ptr_nxt;

    logic [c_lanes-1:0]             w_en;
    logic [c_lanes-1:0][ADDR_W-1:0] w_addr;
    logic [c_lanes-1:0][1:0]        w_cnt;
    logic [c_lanes-1:0]             w_taken;
    logic [c_lanes-1:0]             w_push_en;

    logic [CW-1:0]     w_count;
    logic [CW-1:0]     w_free;
    logic [CW-1:0]     w_free_after;
    logic [2:0]        w_acc;
    logic [2:0]        w_nen;
    logic [2:0]        w_drop_inc;
    logic [1:0]        w_pop_n;
    logic              w_coal;
    logic [DROP_W:0]   w_drop_sum;

    logic [ADDR_W-1:0] w_h0_addr;
    logic [1:0]        w_h0_upd;
    logic [1:0]        w_h0_cnt;
    logic              w_h0_taken;
    logic [ADDR_W-1:0] w_h1_addr;
    logic [1:0]        w_h1_upd;
    logic              w_h1_taken;

    logic [ADDR_W-1:0] w_wr0_addr_nxt;
    logic [1:0]        w_wr0_data_nxt;
    logic              w_wr0_wen_nxt;
    logic [ADDR_W-1:0] w_wr1_addr_nxt;
    logic [1:0]        w_wr1_data_nxt;
    logic              w_wr1_wen_nxt;
    logic [DROP_W-1:0] w_drop_nxt;
    logic              w_stall_nxt;

    logic [ADDR_W-1:0] r_wr0_addr;
    logic [1:0]        r_wr0_data;
    logic              r_wr0_wen;
    logic [ADDR_W-1:0] r_wr1_addr;
    logic [1:0]        r_wr1_data;
    logic              r_wr1_wen;
    logic [DROP_W-1:0] r_drop;
    logic              r_stall;

    assign w_en    = {res3_en, res2_en, res1_en, res0_en};
    assign w_addr  = {res3_addr, res2_addr, res1_addr, res0_addr};
    assign w_cnt   = {res3_cnt, res2_cnt, res1_cnt, res0_cnt};
    assign w_taken = {res3_taken, res2_taken, res1_taken, res0_taken};
    assign w_nen   = 3'(w_en[0]) + 3'(w_en[1]) + 3'(w_en[2]) + 3'(w_en[3]);

    assign w_push_en = (r_state == c_st_run) ? w_en : '0;

    // Pop is decided on the start-of-cycle count, so same-cycle pushes wait one cycle
    always_comb begin
        w_pop_n = 2'd0;
        if (r_state == c_st_run)
            w_pop_n = (w_count >= CW'(2)) ? 2'd2 : {1'b0, w_count[0]};
    end

    anticipator_upd_fifo #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_en     (w_push_en),
        .push_addr   (w_addr),
        .push_cnt    (w_cnt),
        .push_taken  (w_taken),
        .pop_n       (w_pop_n),
        .count       (w_count),
        .free        (w_free),
        .push_acc    (w_acc),
        .head0_addr  (w_h0_addr),
        .head0_upd   (w_h0_upd),
        .head0_cnt   (w_h0_cnt),
        .head0_taken (w_h0_taken),
        .head1_addr  (w_h1_addr),
        .head1_upd   (w_h1_upd),
        .head1_taken (w_h1_taken)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_st_init;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        if (r_state == c_st_init) begin
            w_ptr_nxt = r_ptr + ADDR_W'(2);
            if (r_ptr == c_ptr_last)
                w_state_nxt = c_st_run;
        end
    end

    always_comb begin
        w_wr0_addr_nxt = '0;
        w_wr0_data_nxt = '0;
        w_wr0_wen_nxt  = 1'b0;
        w_wr1_addr_nxt = '0;
        w_wr1_data_nxt = '0;
        w_wr1_wen_nxt  = 1'b0;
        w_coal         = 1'b0;
        w_drop_inc     = w_nen;
        if (r_state == c_st_init) begin
            w_wr0_addr_nxt = r_ptr;
            w_wr0_data_nxt = INIT_VAL;
            w_wr0_wen_nxt  = 1'b1;
            w_wr1_addr_nxt = r_ptr + ADDR_W'(1);
            w_wr1_data_nxt = INIT_VAL;
            w_wr1_wen_nxt  = 1'b1;
        end else begin
            w_drop_inc     = w_nen - w_acc;
            w_coal         = (w_pop_n == 2'd2) && (w_h0_addr == w_h1_addr);
            w_wr0_addr_nxt = w_h0_addr;
            w_wr0_data_nxt = w_h0_upd;
            w_wr0_wen_nxt  = (w_pop_n != 2'd0) && !w_coal;
            w_wr1_addr_nxt = w_h1_addr;
            // A same-index pair folds into one write with both updates applied in order
            w_wr1_data_nxt = w_coal ? ant_sat_upd(ant_sat_upd(w_h0_cnt, w_h0_taken), w_h1_taken)
                                    : w_h1_upd;
            w_wr1_wen_nxt  = (w_pop_n == 2'd2);
        end
        w_free_after = w_free - CW'(w_acc) + CW'(w_pop_n);
        w_stall_nxt  = (w_free_after < CW'(4)) || (w_state_nxt != c_st_run);
        w_drop_sum   = {1'b0, r_drop} + (DROP_W+1)'(w_drop_inc);
        w_drop_nxt   = w_drop_sum[DROP_W] ? '1 : w_drop_sum[DROP_W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr0_addr <= '0;
            r_wr0_data <= '0;
            r_wr0_wen  <= 1'b0;
            r_wr1_addr <= '0;
            r_wr1_data <= '0;
            r_wr1_wen  <= 1'b0;
            r_drop     <= '0;
            r_stall    <= 1'b1;
        end else begin
            r_wr0_addr <= w_wr0_addr_nxt;
            r_wr0_data <= w_wr0_data_nxt;
            r_wr0_wen  <= w_wr0_wen_nxt;
            r_wr1_addr <= w_wr1_addr_nxt;
            r_wr1_data <= w_wr1_data_nxt;
            r_wr1_wen  <= w_wr1_wen_nxt;
            r_drop     <= w_drop_nxt;
            r_stall    <= w_stall_nxt;
        end
    end

    assign write0_addr = r_wr0_addr;
    assign write0_data = r_wr0_data;
    assign write0_wen  = r_wr0_wen;
    assign write1_addr = r_wr1_addr;
    assign write1_data = r_wr1_data;
    assign write1_wen  = r_wr1_wen;
    assign drop_cnt    = r_drop;
    assign res_stall   = r_stall;
    assign init_done   = (r_state == c_st_run);

endmodule

`default_nettype wire

// File: tb/tb_anticipator_update.sv
// ============================================================================
// Module : tb_anticipator_update
// Brief  : Scoreboard bench for anticipator_update against a queue-level model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_anticipator_update;

    localparam int ADDR_W = 12;
    localparam int DEPTH  = 16;
    localparam int DROP_W = 16;
    localparam int NENT   = 4096;

    typedef struct {
        logic [11:0] a;
        logic [1:0]  c;
        logic        t;
    } upd_t;

    typedef struct {
        logic        w0;
        logic [11:0] a0;
        logic [1:0]  d0;
        logic        w1;
        logic [11:0] a1;
        logic [1:0]  d1;
    } wr_t;

    logic clk = 1'b0;
    logic rst;
    logic [3:0]  en;
    logic [11:0] addr [4];
    logic [1:0]  cnt  [4];
    logic [3:0]  tk;

    logic              res_stall;
    logic [ADDR_W-1:0] write0_addr, write1_addr;
    logic [1:0]        write0_data, write1_data;
    logic              write0_wen, write1_wen;
    logic              init_done;
    logic [DROP_W-1:0] drop_cnt;

    int checks   = 0;
    int failures = 0;

    upd_t m_q   [$];
    wr_t  exp_q [$];
    int   m_drop;
    bit   m_run;
    int   m_ptr;
    bit   m_stall;
    bit   seen_stall;
    logic [1:0] ram [NENT];

    anticipator_update dut (
        .clk        (clk),
        .rst        (rst),
        .res0_en    (en[0]), .res0_addr(addr[0]), .res0_cnt(cnt[0]), .res0_taken(tk[0]),
        .res1_en    (en[1]), .res1_addr(addr[1]), .res1_cnt(cnt[1]), .res1_taken(tk[1]),
        .res2_en    (en[2]), .res2_addr(addr[2]), .res2_cnt(cnt[2]), .res2_taken(tk[2]),
        .res3_en    (en[3]), .res3_addr(addr[3]), .res3_cnt(cnt[3]), .res3_taken(tk[3]),
        .res_stall  (res_stall),
        .write0_addr(write0_addr),
        .write0_data(write0_data),
        .write0_wen (write0_wen),
        .write1_addr(write1_addr),
        .write1_data(write1_data),
        .write1_wen (write1_wen),
        .init_done  (init_done),
        .drop_cnt   (drop_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [1:0] f(input logic [1:0] c, input logic t);
        int v;
        v = int'(c) + (t ? 1 : -1);
        if (v > 3) v = 3;
        if (v < 0) v = 0;
        return v[1:0];
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: advances one step per clock edge from the inputs presented
    initial begin
        int  nen, sz0, n, fr, acc, drops;
        upd_t a, b, u;
        wr_t e;
        m_drop = 0; m_run = 0; m_ptr = 0; m_stall = 1;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_q.delete(); exp_q.delete();
                m_drop = 0; m_run = 0; m_ptr = 0; m_stall = 1;
            end else begin
                nen = 0;
                for (int l = 0; l < 4; l++) if (en[l]) nen++;
                drops = 0;
                if (!m_run) begin
                    e = '{1'b1, 12'(m_ptr), 2'b10, 1'b1, 12'(m_ptr + 1), 2'b10};
                    exp_q.push_back(e);
                    m_ptr += 2;
                    drops = nen;
                    if (m_ptr == NENT) m_run = 1;
                end else begin
                    sz0 = m_q.size();
                    n   = (sz0 < 2) ? sz0 : 2;
                    if (n == 1) begin
                        a = m_q.pop_front();
                        exp_q.push_back('{1'b1, a.a, f(a.c, a.t), 1'b0, 12'h0, 2'b00});
                    end else if (n == 2) begin
                        a = m_q.pop_front();
                        b = m_q.pop_front();
                        if (a.a == b.a)
                            exp_q.push_back('{1'b0, 12'h0, 2'b00, 1'b1, b.a, f(f(a.c, a.t), b.t)});
                        else
                            exp_q.push_back('{1'b1, a.a, f(a.c, a.t), 1'b1, b.a, f(b.c, b.t)});
                    end
                    fr  = DEPTH - sz0;
                    acc = 0;
                    for (int l = 0; l < 4; l++) begin
                        if (en[l]) begin
                            if (acc < fr) begin
                                u = '{addr[l], cnt[l], tk[l]};
                                m_q.push_back(u);
                                acc++;
                            end else begin
                                drops++;
                            end
                        end
                    end
                end
                m_drop = (m_drop + drops > 65535) ? 65535 : m_drop + drops;
                m_stall = !m_run || ((DEPTH - m_q.size()) < 4);
            end
        end
    end

    // Monitor: compares every observed write against the scoreboard queue
    initial begin
        wr_t e;
        int  wcyc, bad;
        bit  init_checked;
        init_checked = 0; wcyc = 0; seen_stall = 0;
        for (int i = 0; i < NENT; i++) ram[i] = 2'b01;
        forever begin
            @(negedge clk);
            if (rst) begin
                init_checked = 0; wcyc = 0;
                for (int i = 0; i < NENT; i++) ram[i] = 2'b01;
                continue;
            end
            if (write0_wen || write1_wen) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", {write0_wen, write1_wen}, 2'b00);
                end else begin
                    e = exp_q.pop_front();
                    chk("wen0", write0_wen, e.w0);
                    chk("wen1", write1_wen, e.w1);
                    if (e.w0 && write0_wen) begin
                        chk("addr0", write0_addr, e.a0);
                        chk("data0", write0_data, e.d0);
                    end
                    if (e.w1 && write1_wen) begin
                        chk("addr1", write1_addr, e.a1);
                        chk("data1", write1_data, e.d1);
                    end
                end
            end else if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("missing_write", {write0_wen, write1_wen}, {e.w0, e.w1});
            end
            if (write0_wen) ram[write0_addr] = write0_data;
            if (write1_wen) ram[write1_addr] = write1_data;
            if (!init_checked) begin
                if (write0_wen && write1_wen) wcyc++;
                if (init_done) begin
                    chk("init_write_cycles", wcyc, 2048);
                    bad = 0;
                    for (int i = 0; i < NENT; i++) if (ram[i] != 2'b10) bad++;
                    chk("init_ram_bad_entries", bad, 0);
                    init_checked = 1;
                end
            end
            chk("drop_cnt", drop_cnt, m_drop);
            chk("init_done", init_done, m_run);
            chk("res_stall", res_stall, m_stall);
            if (res_stall && init_done) seen_stall = 1;
        end
    end

    task automatic lane(input int l, input logic [11:0] a, input logic [1:0] c, input logic t);
        en[l] = 1'b1; addr[l] = a; cnt[l] = c; tk[l] = t;
    endtask

    task automatic rand_lanes(input logic [3:0] mask, input int amax);
        for (int l = 0; l < 4; l++) begin
            en[l]   = mask[l];
            addr[l] = 12'($urandom_range(0, amax));
            cnt[l]  = 2'($urandom_range(0, 3));
            tk[l]   = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic wait_init();
        int k = 0;
        while (!init_done && k < 5000) begin
            @(negedge clk);
            k++;
        end
        chk("init_reached", init_done, 1'b1);
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        en  = '0;
        tk  = '0;
        for (int l = 0; l < 4; l++) begin addr[l] = '0; cnt[l] = '0; end
        repeat (2) @(negedge clk);
        #1;
        chk("rst_wen0", write0_wen, 1'b0);
        chk("rst_wen1", write1_wen, 1'b0);
        chk("rst_stall", res_stall, 1'b1);
        chk("rst_init_done", init_done, 1'b0);
        chk("rst_drop", drop_cnt, 0);
        @(negedge clk);
        rst = 1'b0;

        wait_init();

        // Single updates, then a same-index pair in one cycle
        @(negedge clk); lane(0, 12'h123, 2'd3, 1'b1);
        @(negedge clk); en = '0;
        repeat (3) @(negedge clk);
        lane(0, 12'h123, 2'd0, 1'b0);
        @(negedge clk); en = '0;
        repeat (3) @(negedge clk);
        lane(0, 12'h200, 2'd1, 1'b1);
        lane(1, 12'h200, 2'd1, 1'b1);
        @(negedge clk); en = '0;
        repeat (3) @(negedge clk);

        // Saturating burst that ignores the stall
        repeat (6) begin
            rand_lanes(4'hF, 7);
            @(negedge clk);
        end
        en = '0;
        chk("stall_seen_in_burst", seen_stall, 1'b1);
        repeat (12) @(negedge clk);

        // Mixed traffic, mostly honouring the stall
        repeat (300) begin
            if (!res_stall || $urandom_range(0, 3) == 0)
                rand_lanes(4'($urandom_range(0, 15)), 15);
            else
                en = '0;
            @(negedge clk);
        end
        en = '0;
        repeat (12) @(negedge clk);

        // Reset with the queue partly filled
        rand_lanes(4'hF, 4095);
        @(negedge clk);
        rand_lanes(4'hF, 4095);
        @(negedge clk);
        en = '0;
        #2 rst = 1'b1;
        #1;
        chk("midrst_wen0", write0_wen, 1'b0);
        chk("midrst_wen1", write1_wen, 1'b0);
        chk("midrst_drop", drop_cnt, 0);
        chk("midrst_init_done", init_done, 1'b0);
        chk("midrst_stall", res_stall, 1'b1);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Updates offered during the sweep are all dropped
        repeat (40) begin
            rand_lanes(4'($urandom_range(0, 15)), 4095);
            @(negedge clk);
        end
        en = '0;
        wait_init();

        repeat (60) begin
            if (!res_stall)
                rand_lanes(4'($urandom_range(0, 15)), 31);
            else
                en = '0;
            @(negedge clk);
        end
        en = '0;
        repeat (20) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
